// File: rtl/array8_minmax_scan.sv
// Scan engine: walks the 8-entry array read port and reports unsigned min/max with indices.
// Optional sum output is enabled by defining ARRAY8_SCAN_SUM_EN.
module array8_minmax_scan #(
  parameter int unsigned DW = 16,
  parameter int unsigned N  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          arr_rd_en,
  output logic [2:0]    arr_rd_idx,
  input  logic [DW-1:0] arr_rd_data,
  output logic [DW-1:0] min_val,
  output logic [2:0]    min_idx,
  output logic [DW-1:0] max_val,
  output logic [2:0]    max_idx
`ifdef ARRAY8_SCAN_SUM_EN
  ,
  output logic [DW+2:0] sum
`endif
);

  localparam logic [2:0] LAST = 3'(N - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t        state;
  logic          cap_valid;
  logic [2:0]    cap_idx;
  logic [DW-1:0] wmin, wmax, nmin, nmax;
  logic [2:0]    wmin_idx, wmax_idx, nmin_idx, nmax_idx;
`ifdef ARRAY8_SCAN_SUM_EN
  logic [DW+2:0] wsum, nsum;
`endif

  // Next working values; the outputs load from these in DRAIN so the
  // index-7 word is already folded in when DONE presents the result.
  always_comb begin
    nmin     = wmin;
    nmin_idx = wmin_idx;
    nmax     = wmax;
    nmax_idx = wmax_idx;
    if (cap_valid) begin
      if (cap_idx == '0 || arr_rd_data < wmin) begin
        nmin     = arr_rd_data;
        nmin_idx = cap_idx;
      end
      if (cap_idx == '0 || arr_rd_data > wmax) begin
        nmax     = arr_rd_data;
        nmax_idx = cap_idx;
      end
    end
`ifdef ARRAY8_SCAN_SUM_EN
    nsum = wsum;
    if (cap_valid) nsum = wsum + {3'b000, arr_rd_data};
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      arr_rd_en  <= 1'b0;
      arr_rd_idx <= '0;
      cap_valid  <= 1'b0;
      cap_idx    <= '0;
      wmin       <= '0;
      wmin_idx   <= '0;
      wmax       <= '0;
      wmax_idx   <= '0;
      min_val    <= '0;
      min_idx    <= '0;
      max_val    <= '0;
      max_idx    <= '0;
`ifdef ARRAY8_SCAN_SUM_EN
      wsum       <= '0;
      sum        <= '0;
`endif
    end else begin
      cap_valid <= arr_rd_en;
      cap_idx   <= arr_rd_idx;
      wmin      <= nmin;
      wmin_idx  <= nmin_idx;
      wmax      <= nmax;
      wmax_idx  <= nmax_idx;
`ifdef ARRAY8_SCAN_SUM_EN
      wsum      <= nsum;
`endif
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= READ;
            busy       <= 1'b1;
            arr_rd_en  <= 1'b1;
            arr_rd_idx <= '0;
            cap_valid  <= 1'b0;
            cap_idx    <= '0;
`ifdef ARRAY8_SCAN_SUM_EN
            wsum       <= '0;
`endif
          end
        end
        READ: begin
          if (arr_rd_idx == LAST) begin
            state      <= DRAIN;
            arr_rd_en  <= 1'b0;
            arr_rd_idx <= '0;
          end else begin
            arr_rd_idx <= arr_rd_idx + 3'd1;
          end
        end
        DRAIN: begin
          state   <= DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
          min_val <= nmin;
          min_idx <= nmin_idx;
          max_val <= nmax;
          max_idx <= nmax_idx;
`ifdef ARRAY8_SCAN_SUM_EN
          sum     <= nsum;
`endif
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_array8_minmax_scan.sv
// Self-checking bench for array8_minmax_scan with a registered-read array model.
// Define ARRAY8_SCAN_SUM_EN to also check the sum output.
module tb_array8_minmax_scan;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, arr_rd_en;
  logic [2:0]    arr_rd_idx;
  logic [DW-1:0] arr_rd_data = '0;
  logic [DW-1:0] min_val, max_val;
  logic [2:0]    min_idx, max_idx;
`ifdef ARRAY8_SCAN_SUM_EN
  logic [DW+2:0] sum;
  logic [DW+2:0] esum, psum;
`endif

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem [8];
  logic [DW-1:0] emin, emax, pmin, pmax;
  logic [2:0]    eimin, eimax, pimin, pimax;

  array8_minmax_scan #(.DW(DW), .N(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .arr_rd_en   (arr_rd_en),
    .arr_rd_idx  (arr_rd_idx),
    .arr_rd_data (arr_rd_data),
    .min_val     (min_val),
    .min_idx     (min_idx),
    .max_val     (max_val),
    .max_idx     (max_idx)
`ifdef ARRAY8_SCAN_SUM_EN
    ,
    .sum         (sum)
`endif
  );

  always #5 clk = ~clk;

  // Array read port: data registered one cycle after rd_en.
  always @(posedge clk) if (arr_rd_en) arr_rd_data <= mem[arr_rd_idx];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: min/max by value, then the lowest index holding that value.
  task automatic model();
    emin = mem[0];
    emax = mem[0];
`ifdef ARRAY8_SCAN_SUM_EN
    esum = '0;
`endif
    foreach (mem[i]) begin
      if (mem[i] < emin) emin = mem[i];
      if (mem[i] > emax) emax = mem[i];
`ifdef ARRAY8_SCAN_SUM_EN
      esum += {3'b000, mem[i]};
`endif
    end
    for (int i = 7; i >= 0; i--) begin
      if (mem[i] == emin) eimin = 3'(i);
      if (mem[i] == emax) eimax = 3'(i);
    end
  endtask

  task automatic take_result();
    pmin = emin; pimin = eimin; pmax = emax; pimax = eimax;
`ifdef ARRAY8_SCAN_SUM_EN
    psum = esum;
`endif
  endtask

  task automatic check_outs(input string tag);
    chk({tag, " min_val"}, min_val, pmin);
    chk({tag, " min_idx"}, min_idx, pimin);
    chk({tag, " max_val"}, max_val, pmax);
    chk({tag, " max_idx"}, max_idx, pimax);
`ifdef ARRAY8_SCAN_SUM_EN
    chk({tag, " sum"}, sum, psum);
`endif
  endtask

  // One scan from a start pulse at C0; mask bit c drives start high during Cc.
  task automatic run_scan(input string tag, input logic [15:0] mask);
    @(negedge clk); start = 1'b1;
    @(posedge clk); model();
    for (int c = 1; c <= 14; c++) begin
      #1 start = mask[c];
      @(negedge clk);
      chk($sformatf("%s busy C%0d", tag, c), busy, (c <= 9));
      chk($sformatf("%s done C%0d", tag, c), done, (c == 10));
      chk($sformatf("%s rd_en C%0d", tag, c), arr_rd_en, (c <= 8));
      chk($sformatf("%s rd_idx C%0d", tag, c), arr_rd_idx, (c <= 8) ? c - 1 : 0);
      if (c == 10) take_result();
      if (c == 5 || c == 10 || c == 14) check_outs($sformatf("%s C%0d", tag, c));
      @(posedge clk);
    end
    #1 start = 1'b0;
  endtask

  initial begin
    int ph, dcount;
    pmin = '0; pimin = '0; pmax = '0; pimax = '0;
`ifdef ARRAY8_SCAN_SUM_EN
    psum = '0;
`endif
    mem = '{16'd236, 16'd175, 16'd85, 16'd13, 16'd120, 16'd46, 16'd13, 16'd99};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst rd_en", arr_rd_en, 0);
    chk("rst rd_idx", arr_rd_idx, 0);
    check_outs("rst");
    reset = 1'b0;

    run_scan("preset", '0);

    mem[5] = 16'd65535;
    mem[7] = 16'd0;
    run_scan("extremes", '0);

    foreach (mem[i]) mem[i] = 16'd42;
    run_scan("all42", '0);

    // start held high for C0..C29: scans accepted at E0, E11, E22
    @(negedge clk); start = 1'b1;
    @(posedge clk); model();
    for (int c = 1; c <= 33; c++) begin
      #1 if (c == 30) start = 1'b0;
      @(negedge clk);
      ph = c % 11;
      chk($sformatf("hold busy C%0d", c), busy, (ph >= 1 && ph <= 9));
      chk($sformatf("hold done C%0d", c), done, (ph == 10));
      chk($sformatf("hold rd_idx C%0d", c), arr_rd_idx, (ph >= 1 && ph <= 8) ? ph - 1 : 0);
      if (ph == 10) begin
        take_result();
        check_outs($sformatf("hold C%0d", c));
      end
      @(posedge clk);
    end

    for (int r = 0; r < 6; r++) begin
      foreach (mem[i]) mem[i] = (r < 3) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      run_scan($sformatf("rand%0d", r), '0);
    end

    mem = '{16'd236, 16'd175, 16'd85, 16'd13, 16'd120, 16'd46, 16'd13, 16'd99};
    run_scan("ignored_start", 16'b0000_0100_0001_0000);

    // reset asserted during C5 of a scan
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    pmin = '0; pimin = '0; pmax = '0; pimax = '0;
`ifdef ARRAY8_SCAN_SUM_EN
    psum = '0;
`endif
    @(negedge clk);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst rd_en", arr_rd_en, 0);
    chk("midrst rd_idx", arr_rd_idx, 0);
    check_outs("midrst");
    dcount = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("midrst no done", dcount, 0);
    run_scan("post_rst", '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
